frame_bank_mgr: RTL and testbench
=================================

Name: frame_bank_mgr

Overview:
- Parametrised N-bank frame-buffer manager in the DDR clock domain (phy_clk).
- Generates the write and read burst base addresses for the dual-FIFO DDR controller and decides which bank each side uses.
- Generalises the two-bank switch to 2..4 banks with configurable frame size and burst length.
- Always reads the newest complete frame and never writes the bank being read. Counts dropped and repeated frames.

Parameters:
- NUM_BANKS, 3, number of frame banks (2..4).
- BANK_W, 2, bank-select width; must satisfy 2^BANK_W >= NUM_BANKS.
- OFFSET_W, 23, word-offset width within a bank.
- FRAME_WORDS, 65280, 32-bit words per frame; must be a nonzero multiple of BURST_LEN.
- BURST_LEN, 48, words per DDR burst.

Ports:
- clk  in  1  DDR controller clock (phy_clk).
- rst  in  1  asynchronous, active-high reset.
- ddr_init_done  in  1  DDR calibrated; while low, both sides are held idle.
- wr_frame_start  in  1  1-cycle pulse: new source frame begins (camera frame switch).
- wr_burst_finish  in  1  1-cycle pulse: one write burst completed.
- rd_frame_start  in  1  1-cycle pulse: display starts a new frame.
- rd_burst_finish  in  1  1-cycle pulse: one read burst completed.
- wr_addr  out  BANK_W+OFFSET_W  {wr_bank, wr_offset}.
- rd_addr  out  BANK_W+OFFSET_W  {rd_bank, rd_offset}.
- wr_bank  out  BANK_W  current write bank.
- rd_bank  out  BANK_W  current read bank.
- wr_active  out  1  write side is in W_RUN.
- rd_active  out  1  read side is in R_RUN.
- wr_frame_done  out  1  1-cycle pulse: frame fully written.
- rd_frame_done  out  1  1-cycle pulse: frame fully read.
- drop_cnt  out  16  frames discarded; saturates at 0xFFFF.
- repeat_cnt  out  16  frames displayed again; saturates at 0xFFFF.

Behaviour:
- Clocking and reset: single clock; reset is asynchronous and active-high.
- Reset values:
  - wr_bank=0, rd_bank=NUM_BANKS-1, both offsets 0.
  - latest_bank=0, latest_valid=0.
  - All pulse and active outputs 0; both counters 0.
  - Both FSMs in IDLE.
- Write FSM:
  - W_IDLE -> W_RUN on wr_frame_start while ddr_init_done=1; wr_offset set to 0.
  - In W_RUN, each wr_burst_finish adds BURST_LEN to wr_offset.
  - Frame end is a wr_burst_finish arriving with wr_offset == FRAME_WORDS-BURST_LEN. On that cycle the next edge:
    - enters W_DONE, where wr_frame_done is 1 for exactly one cycle;
    - sets latest_bank<=wr_bank and latest_valid<=1;
    - resets wr_offset to 0.
  - W_DONE -> W_IDLE unconditionally.
- Next write bank, computed in W_DONE:
  - c1 = (wr_bank+1) mod NUM_BANKS.
  - If c1 != rd_bank_next, use c1.
  - Else c2 = (c1+1) mod NUM_BANKS. If c2 != wr_bank, use c2.
  - Else (only possible with NUM_BANKS=2) keep wr_bank and increment drop_cnt.
- wr_frame_start while in W_RUN (truncated frame): wr_offset<=0, bank unchanged, drop_cnt+1, stay in W_RUN. No wr_frame_done.
- Read FSM:
  - R_IDLE -> R_RUN on rd_frame_start while ddr_init_done=1 and latest_valid=1. Otherwise the pulse is ignored.
  - On entry: if latest_bank != rd_bank, rd_bank<=latest_bank; else repeat_cnt+1. rd_offset<=0.
  - Each rd_burst_finish adds BURST_LEN to rd_offset.
  - At frame end, rd_frame_done pulses for 1 cycle, rd_offset<=0, and the FSM returns to R_IDLE.
  - rd_frame_start while in R_RUN re-applies the entry rule and restarts from offset 0.
- Simultaneous W_DONE and read entry: the read side latches the pre-update latest_bank. rd_bank_next is the value rd_bank will hold after that edge, and the write selection must avoid it. wr_bank must never equal rd_bank while both sides are active.
- A burst_finish pulse in IDLE is ignored.
- ddr_init_done falling: both FSMs go to IDLE the next edge; offsets clear; banks, latest_bank and counters are held.
- Latency: wr_addr/rd_addr update 1 cycle after the causing pulse. Outputs are registered, with no combinational input-to-output path.
- Counters increment by at most 1 per cycle. If two drop events coincide, count 1.

Optional Feature:
- Macro: FRAME_BANK_FREEZE_EN.
- Defined:
  - Adds input freeze (1 bit).
  - While freeze=1, read entry keeps rd_bank unconditionally and does not increment repeat_cnt.
  - The write side keeps cycling the remaining banks under the normal avoidance rule.
- Undefined: no freeze port; behaviour as above.

Test Plan:
- FRAME_WORDS=96, BURST_LEN=48, N=3. wr_frame_start, then 2 wr_burst_finish -> wr_addr goes 0x0000000 then 0x0000030; wr_frame_done pulses once; latest_bank=0; wr_bank=1.
- After that write, rd_frame_start -> rd_bank=0, rd_active=1. A second write frame -> wr_bank steps 1->2, skipping 0. A third write completes -> wr_bank=1.
- rd_frame_start twice with no new frame written -> rd_bank unchanged, repeat_cnt=1.
- N=2, rd_bank=1 active, write frame into bank 0 completes -> wr_bank stays 0, drop_cnt=1.
- wr_frame_start after 1 burst in W_RUN -> wr_offset back to 0, drop_cnt+1, no wr_frame_done. Also assert rst mid-burst -> all outputs at reset values immediately (asynchronous).
- Same-cycle W_DONE and rd_frame_start, N=3 -> rd_bank takes the old latest_bank, new wr_bank differs from it, and there is no bank collision. With FRAME_BANK_FREEZE_EN and freeze=1 -> rd_bank is constant across 3 written frames.

Source files
------------

// File: rtl/frame_bank_mgr.sv
// N-bank frame-buffer manager: write/read burst base addresses and bank arbitration in the DDR clock domain.
// Optional read-bank freeze input is enabled by defining FRAME_BANK_FREEZE_EN.
module frame_bank_mgr #(
    parameter int NUM_BANKS   = 3,
    parameter int BANK_W      = 2,
    parameter int OFFSET_W    = 23,
    parameter int FRAME_WORDS = 65280,
    parameter int BURST_LEN   = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ddr_init_done,
    input  logic                       wr_frame_start,
    input  logic                       wr_burst_finish,
    input  logic                       rd_frame_start,
    input  logic                       rd_burst_finish,
`ifdef FRAME_BANK_FREEZE_EN
    input  logic                       freeze,
`endif
    output logic [BANK_W+OFFSET_W-1:0] wr_addr,
    output logic [BANK_W+OFFSET_W-1:0] rd_addr,
    output logic [BANK_W-1:0]          wr_bank,
    output logic [BANK_W-1:0]          rd_bank,
    output logic                       wr_active,
    output logic                       rd_active,
    output logic                       wr_frame_done,
    output logic                       rd_frame_done,
    output logic [15:0]                drop_cnt,
    output logic [15:0]                repeat_cnt
);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_RUN  = 2'd1;
    localparam logic [1:0] W_DONE = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RUN  = 1'b1;

    localparam logic [BANK_W-1:0]   LAST_BANK = BANK_W'(NUM_BANKS - 1);
    localparam logic [BANK_W-1:0]   BANK_ONE  = BANK_W'(1);
    localparam logic [OFFSET_W-1:0] LAST_OFF  = OFFSET_W'(FRAME_WORDS - BURST_LEN);
    localparam logic [OFFSET_W-1:0] BURST_INC = OFFSET_W'(BURST_LEN);

    logic [1:0]          wr_state;
    logic [0:0]          rd_state;
    logic [OFFSET_W-1:0] wr_offset;
    logic [OFFSET_W-1:0] rd_offset;
    logic [BANK_W-1:0]   latest_bank;
    logic                latest_valid;
    logic                freeze_i;

    logic                rd_entry;
    logic [BANK_W-1:0]   rd_bank_next;
    logic [BANK_W-1:0]   cand1;
    logic [BANK_W-1:0]   cand2;
    logic [BANK_W-1:0]   wr_bank_sel;
    logic                wr_sel_drop;
    logic                drop_evt;
    logic                repeat_evt;

`ifdef FRAME_BANK_FREEZE_EN
    assign freeze_i = freeze;
`else
    assign freeze_i = 1'b0;
`endif

    assign wr_addr   = {wr_bank, wr_offset};
    assign rd_addr   = {rd_bank, rd_offset};
    assign wr_active = (wr_state == W_RUN);
    assign rd_active = (rd_state == R_RUN);

    // The write-bank choice must avoid the bank the reader holds after this same edge.
    always_comb begin
        rd_entry     = ddr_init_done && rd_frame_start && latest_valid;
        rd_bank_next = (rd_entry && !freeze_i) ? latest_bank : rd_bank;
        cand1        = (wr_bank == LAST_BANK) ? '0 : wr_bank + BANK_ONE;
        cand2        = (cand1 == LAST_BANK) ? '0 : cand1 + BANK_ONE;
        wr_sel_drop  = (cand1 == rd_bank_next) && (cand2 == wr_bank);
        if (cand1 != rd_bank_next) begin
            wr_bank_sel = cand1;
        end else if (cand2 != wr_bank) begin
            wr_bank_sel = cand2;
        end else begin
            wr_bank_sel = wr_bank;
        end
        drop_evt   = ddr_init_done &&
                     (((wr_state == W_RUN) && wr_frame_start) ||
                      ((wr_state == W_DONE) && wr_sel_drop));
        repeat_evt = rd_entry && !freeze_i && (latest_bank == rd_bank);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state      <= W_IDLE;
            wr_bank       <= '0;
            wr_offset     <= '0;
            latest_bank   <= '0;
            latest_valid  <= 1'b0;
            wr_frame_done <= 1'b0;
        end else begin
            wr_frame_done <= 1'b0;
            if (!ddr_init_done) begin
                wr_state  <= W_IDLE;
                wr_offset <= '0;
            end else begin
                case (wr_state)
                    W_IDLE: begin
                        if (wr_frame_start) begin
                            wr_state  <= W_RUN;
                            wr_offset <= '0;
                        end
                    end
                    W_RUN: begin
                        if (wr_frame_start) begin
                            wr_offset <= '0;
                        end else if (wr_burst_finish) begin
                            if (wr_offset == LAST_OFF) begin
                                wr_state      <= W_DONE;
                                wr_frame_done <= 1'b1;
                                latest_bank   <= wr_bank;
                                latest_valid  <= 1'b1;
                                wr_offset     <= '0;
                            end else begin
                                wr_offset <= wr_offset + BURST_INC;
                            end
                        end
                    end
                    W_DONE: begin
                        wr_bank  <= wr_bank_sel;
                        wr_state <= W_IDLE;
                    end
                    default: wr_state <= W_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state      <= R_IDLE;
            rd_bank       <= LAST_BANK;
            rd_offset     <= '0;
            rd_frame_done <= 1'b0;
        end else begin
            rd_frame_done <= 1'b0;
            if (!ddr_init_done) begin
                rd_state  <= R_IDLE;
                rd_offset <= '0;
            end else if (rd_entry) begin
                rd_state  <= R_RUN;
                rd_bank   <= rd_bank_next;
                rd_offset <= '0;
            end else if ((rd_state == R_RUN) && rd_burst_finish) begin
                if (rd_offset == LAST_OFF) begin
                    rd_frame_done <= 1'b1;
                    rd_offset     <= '0;
                    rd_state      <= R_IDLE;
                end else begin
                    rd_offset <= rd_offset + BURST_INC;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt   <= '0;
            repeat_cnt <= '0;
        end else begin
            if (drop_evt && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (repeat_evt && (repeat_cnt != '1)) begin
                repeat_cnt <= repeat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_bank_mgr.sv
// Bench for frame_bank_mgr: a 3-bank and a 2-bank instance share stimulus and are checked
// every cycle against a frame-level reference model; FRAME_BANK_FREEZE_EN adds a freeze scenario.
module tb_frame_bank_mgr;

    localparam int FW = 96;
    localparam int BL = 48;
    localparam int BW = 2;
    localparam int OW = 23;

    typedef struct packed {
        bit w_run;
        bit w_done;
        int w_off;
        int wr_bank;
        bit r_run;
        int r_off;
        int rd_bank;
        int latest;
        bit lvalid;
        bit wfd;
        bit rfd;
        int drop;
        int rep;
    } mdl_t;

    logic clk = 1'b0;
    logic rst, init, wfs, wbf, rfs, rbf;
`ifdef FRAME_BANK_FREEZE_EN
    logic freeze;
`endif

    logic [BW+OW-1:0] wr_addr [2];
    logic [BW+OW-1:0] rd_addr [2];
    logic [BW-1:0]    wr_bank [2];
    logic [BW-1:0]    rd_bank [2];
    logic             wr_active [2];
    logic             rd_active [2];
    logic             wr_frame_done [2];
    logic             rd_frame_done [2];
    logic [15:0]      drop_cnt [2];
    logic [15:0]      repeat_cnt [2];

    mdl_t m [2];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    frame_bank_mgr #(.NUM_BANKS(3), .BANK_W(BW), .OFFSET_W(OW), .FRAME_WORDS(FW), .BURST_LEN(BL)) dut3 (
        .clk(clk), .rst(rst), .ddr_init_done(init),
        .wr_frame_start(wfs), .wr_burst_finish(wbf),
        .rd_frame_start(rfs), .rd_burst_finish(rbf),
`ifdef FRAME_BANK_FREEZE_EN
        .freeze(freeze),
`endif
        .wr_addr(wr_addr[0]), .rd_addr(rd_addr[0]),
        .wr_bank(wr_bank[0]), .rd_bank(rd_bank[0]),
        .wr_active(wr_active[0]), .rd_active(rd_active[0]),
        .wr_frame_done(wr_frame_done[0]), .rd_frame_done(rd_frame_done[0]),
        .drop_cnt(drop_cnt[0]), .repeat_cnt(repeat_cnt[0])
    );

    frame_bank_mgr #(.NUM_BANKS(2), .BANK_W(BW), .OFFSET_W(OW), .FRAME_WORDS(FW), .BURST_LEN(BL)) dut2 (
        .clk(clk), .rst(rst), .ddr_init_done(init),
        .wr_frame_start(wfs), .wr_burst_finish(wbf),
        .rd_frame_start(rfs), .rd_burst_finish(rbf),
`ifdef FRAME_BANK_FREEZE_EN
        .freeze(freeze),
`endif
        .wr_addr(wr_addr[1]), .rd_addr(rd_addr[1]),
        .wr_bank(wr_bank[1]), .rd_bank(rd_bank[1]),
        .wr_active(wr_active[1]), .rd_active(rd_active[1]),
        .wr_frame_done(wr_frame_done[1]), .rd_frame_done(rd_frame_done[1]),
        .drop_cnt(drop_cnt[1]), .repeat_cnt(repeat_cnt[1])
    );

    function automatic int sat_inc(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    // One clock of the frame-level rules; every decision reads the pre-edge state.
    function automatic mdl_t step(input mdl_t s, input int n, input bit in_init,
                                  input bit in_wfs, input bit in_wbf, input bit in_rfs,
                                  input bit in_rbf, input bit in_frz);
        mdl_t x;
        int   rd_nx;
        int   pick;
        int   cand;
        bit   drop;
        x     = s;
        x.wfd = 1'b0;
        x.rfd = 1'b0;
        drop  = 1'b0;
        if (!in_init) begin
            x.w_run  = 1'b0;
            x.w_done = 1'b0;
            x.w_off  = 0;
            x.r_run  = 1'b0;
            x.r_off  = 0;
            return x;
        end
        rd_nx = s.rd_bank;
        if (in_rfs && s.lvalid) begin
            if (!in_frz) begin
                if (s.latest != s.rd_bank) rd_nx = s.latest;
                else x.rep = sat_inc(s.rep);
            end
            x.r_run = 1'b1;
            x.r_off = 0;
        end else if (s.r_run && in_rbf) begin
            if (s.r_off + BL == FW) begin
                x.rfd   = 1'b1;
                x.r_off = 0;
                x.r_run = 1'b0;
            end else begin
                x.r_off = s.r_off + BL;
            end
        end
        x.rd_bank = rd_nx;
        if (s.w_done) begin
            x.w_done = 1'b0;
            pick = -1;
            for (int k = 1; k <= 2; k++) begin
                cand = (s.wr_bank + k) % n;
                if (pick < 0 && cand != rd_nx && cand != s.wr_bank) pick = cand;
            end
            if (pick < 0) drop = 1'b1;
            else x.wr_bank = pick;
        end else if (s.w_run) begin
            if (in_wfs) begin
                x.w_off = 0;
                drop    = 1'b1;
            end else if (in_wbf) begin
                if (s.w_off + BL == FW) begin
                    x.w_run  = 1'b0;
                    x.w_done = 1'b1;
                    x.wfd    = 1'b1;
                    x.latest = s.wr_bank;
                    x.lvalid = 1'b1;
                    x.w_off  = 0;
                end else begin
                    x.w_off = s.w_off + BL;
                end
            end
        end else if (in_wfs) begin
            x.w_run = 1'b1;
            x.w_off = 0;
        end
        if (drop) x.drop = sat_inc(s.drop);
        return x;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k] = '0;
            m[k].rd_bank = (k == 0) ? 2 : 1;
        end
    endtask

    task automatic compare_all();
        string s;
        logic [BW+OW-1:0] ea;
        for (int k = 0; k < 2; k++) begin
            s  = (k == 0) ? "n3" : "n2";
            ea = {m[k].wr_bank[BW-1:0], m[k].w_off[OW-1:0]};
            check({s, ".wr_addr"}, 32'(wr_addr[k]), 32'(ea));
            ea = {m[k].rd_bank[BW-1:0], m[k].r_off[OW-1:0]};
            check({s, ".rd_addr"}, 32'(rd_addr[k]), 32'(ea));
            check({s, ".wr_bank"}, 32'(wr_bank[k]), 32'(m[k].wr_bank));
            check({s, ".rd_bank"}, 32'(rd_bank[k]), 32'(m[k].rd_bank));
            check({s, ".wr_active"}, 32'(wr_active[k]), 32'(m[k].w_run));
            check({s, ".rd_active"}, 32'(rd_active[k]), 32'(m[k].r_run));
            check({s, ".wr_frame_done"}, 32'(wr_frame_done[k]), 32'(m[k].wfd));
            check({s, ".rd_frame_done"}, 32'(rd_frame_done[k]), 32'(m[k].rfd));
            check({s, ".drop_cnt"}, 32'(drop_cnt[k]), 32'(m[k].drop));
            check({s, ".repeat_cnt"}, 32'(repeat_cnt[k]), 32'(m[k].rep));
        end
        check("n3.collision", 32'(wr_active[0] && rd_active[0] && (wr_bank[0] == rd_bank[0])), 32'd0);
    endtask

    task automatic tick();
        bit frz;
        @(posedge clk);
        frz = 1'b0;
`ifdef FRAME_BANK_FREEZE_EN
        frz = freeze;
`endif
        m[0] = step(m[0], 3, init, wfs, wbf, rfs, rbf, frz);
        m[1] = step(m[1], 2, init, wfs, wbf, rfs, rbf, frz);
        #1;
        compare_all();
        wfs = 1'b0;
        wbf = 1'b0;
        rfs = 1'b0;
        rbf = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wfs = 1'b0; wbf = 1'b0; rfs = 1'b0; rbf = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
    endtask

    task automatic write_frame();
        wfs = 1'b1; tick();
        wbf = 1'b1; tick();
        wbf = 1'b1; tick();
        tick();
    endtask

    initial begin
        init = 1'b0;
`ifdef FRAME_BANK_FREEZE_EN
        freeze = 1'b0;
`endif
        do_reset();
        check("rst.wr_addr", 32'(wr_addr[0]), 32'h0);
        check("rst.rd_addr", 32'(rd_addr[0]), 32'h100_0000);
        check("rst.rd_bank_n2", 32'(rd_bank[1]), 32'd1);
        init = 1'b1;

        // First frame: offsets 0 then 0x30, one done pulse, bank advance.
        wfs = 1'b1; tick();
        check("w1.addr0", 32'(wr_addr[0]), 32'h0);
        wbf = 1'b1; tick();
        check("w1.addr30", 32'(wr_addr[0]), 32'h30);
        wbf = 1'b1; tick();
        check("w1.done", 32'(wr_frame_done[0]), 32'd1);
        tick();
        check("w1.done_off", 32'(wr_frame_done[0]), 32'd0);
        check("w1.bank", 32'(wr_bank[0]), 32'd1);
        check("n2.drop_bank", 32'(wr_bank[1]), 32'd0);
        check("n2.drop_cnt", 32'(drop_cnt[1]), 32'd1);

        rfs = 1'b1; tick();
        check("r1.bank", 32'(rd_bank[0]), 32'd0);
        check("r1.active", 32'(rd_active[0]), 32'd1);
        write_frame();
        check("w2.bank", 32'(wr_bank[0]), 32'd2);
        write_frame();
        check("w3.bank", 32'(wr_bank[0]), 32'd1);

        rfs = 1'b1; tick();
        check("r2.bank", 32'(rd_bank[0]), 32'd2);
        rfs = 1'b1; tick();
        check("rep.bank", 32'(rd_bank[0]), 32'd2);
        check("rep.cnt", 32'(repeat_cnt[0]), 32'd1);
        rbf = 1'b1; tick();
        rbf = 1'b1; tick();
        check("r.done", 32'(rd_frame_done[0]), 32'd1);

        // Truncated frame, then asynchronous reset mid-burst.
        wfs = 1'b1; tick();
        wbf = 1'b1; tick();
        wfs = 1'b1; tick();
        check("trunc.addr", 32'(wr_addr[0]), 32'h80_0000);
        check("trunc.drop", 32'(drop_cnt[0]), 32'd1);
        check("trunc.nodone", 32'(wr_frame_done[0]), 32'd0);
        wbf = 1'b1; tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("arst.drop", 32'(drop_cnt[0]), 32'd0);
        check("arst.wr_active", 32'(wr_active[0]), 32'd0);
        do_reset();

        // Read entry coinciding with the completing burst, then with W_DONE itself.
        write_frame();
        wfs = 1'b1; tick();
        wbf = 1'b1; tick();
        wbf = 1'b1; rfs = 1'b1; tick();
        check("sim.rd_old_latest", 32'(rd_bank[0]), 32'd0);
        tick();
        check("sim.wr_bank", 32'(wr_bank[0]), 32'd2);
        wfs = 1'b1; tick();
        wbf = 1'b1; tick();
        wbf = 1'b1; tick();
        rfs = 1'b1; tick();
        check("simd.rd_bank", 32'(rd_bank[0]), 32'd2);
        check("simd.wr_bank", 32'(wr_bank[0]), 32'd0);

        // Randomised traffic including short calibration losses.
        for (int i = 0; i < 4000; i++) begin
            init = ($urandom_range(0, 199) != 0);
            wfs  = ($urandom_range(0, 39) == 0);
            wbf  = ($urandom_range(0, 2) == 0);
            rfs  = ($urandom_range(0, 29) == 0);
            rbf  = ($urandom_range(0, 2) == 0);
            tick();
        end
        init = 1'b1;

`ifdef FRAME_BANK_FREEZE_EN
        begin
            int rd_hold;
            rfs = 1'b1; tick();
            freeze = 1'b1;
            rd_hold = m[0].rd_bank;
            for (int f = 0; f < 3; f++) begin
                write_frame();
                rfs = 1'b1; tick();
                check("frz.rd_bank", 32'(rd_bank[0]), 32'(rd_hold));
            end
            freeze = 1'b0;
            tick();
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
